// File: rtl/frame_stream_source_pkg.sv
// Shared definitions for the frame stream source and its pattern generator.
// Holds the FSM state encoding, the test-pattern mode codes and the pixel
// width shared with the downsampler, upsampler and 5x5 window blocks.
package frame_stream_source_pkg;

  localparam int PIXEL_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HBLANK = 2'd2,
    VBLANK = 2'd3
  } state_t;

  localparam logic [1:0] MODE_HRAMP = 2'd0;
  localparam logic [1:0] MODE_VRAMP = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;
  localparam logic [1:0] MODE_FLAT  = 2'd3;

endpackage

// File: rtl/frame_stream_source_if.sv
// Beat stream carrying pixel data, blanking flag, valid strobe and start of
// frame, plus the downstream ready.
//   master: drives dout, blanking_out, validout, sof; samples ready
//   slave : samples the beat signals; drives ready
interface frame_stream_source_if;
  import frame_stream_source_pkg::*;

  logic [PIXEL_W-1:0] dout;
  logic               blanking_out;
  logic               validout;
  logic               sof;
  logic               ready;

  modport master (output dout, blanking_out, validout, sof, input ready);
  modport slave  (input dout, blanking_out, validout, sof, output ready);

endinterface

// File: rtl/frame_stream_source_pattern_gen.sv
// frame_pattern_gen: purely combinational test-pattern map.
//   mode      in  pattern select (h-ramp, v-ramp, checker, flat)
//   x, y      in  raster coordinates of the beat being generated
//   const_val in  flat-field value
//   frame_cnt in  frame counter (tied to zero when scrolling is not built)
//   p         out pixel value
module frame_pattern_gen
  import frame_stream_source_pkg::*;
#(
  parameter int X_W = 9,
  parameter int Y_W = 9
) (
  input  logic [1:0]         mode,
  input  logic [X_W-1:0]     x,
  input  logic [Y_W-1:0]     y,
  input  logic [PIXEL_W-1:0] const_val,
  input  logic [PIXEL_W-1:0] frame_cnt,
  output logic [PIXEL_W-1:0] p
);

  logic [PIXEL_W-1:0] x8;
  logic [PIXEL_W-1:0] y8;

  // Coordinates are resized to pixel width so ramps wrap modulo 256 and the
  // checker bit exists even when the counters are narrower than 4 bits.
  always_comb begin
    x8 = PIXEL_W'(x);
    y8 = PIXEL_W'(y);
    case (mode)
      MODE_HRAMP: p = x8 + frame_cnt;
      MODE_VRAMP: p = y8 + frame_cnt;
      MODE_CHECK: p = (x8[3] ^ y8[3] ^ frame_cnt[0]) ? {PIXEL_W{1'b1}} : '0;
      default:    p = const_val;
    endcase
  end

endmodule

// File: rtl/frame_stream_source.sv
// frame_stream_source: raster video beat generator with selectable test
// pattern and ready back-pressure.
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   enable        starts frames; only looked at on frame boundaries
//   mode          pattern select, latched at frame start
//   const_val     flat-field value, latched at frame start
//   strm          master side of the beat stream (dout, blanking_out,
//                 validout, sof out; ready in)
// Build option: define FRAME_STREAM_SCROLL_EN to add an 8-bit frame counter
// that scrolls the ramps and flips the checker phase every frame.
// H_BLANK must be at least 1.
module frame_stream_source
  import frame_stream_source_pkg::*;
#(
  parameter int H_ACTIVE = 400,
  parameter int H_BLANK  = 40,
  parameter int V_ACTIVE = 300,
  parameter int V_BLANK  = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [PIXEL_W-1:0] const_val,
  frame_stream_source_if.master strm
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_ACTIVE + V_BLANK;
  localparam int X_W     = $clog2(H_TOTAL);
  localparam int Y_W     = $clog2(V_TOTAL);

  localparam logic [X_W-1:0] X_ACT_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [X_W-1:0] X_LAST     = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0] Y_ACT_LAST = Y_W'(V_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_VBL_1ST  = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] Y_LAST     = Y_W'(V_TOTAL - 1);

  state_t             state, nxt_state;
  logic [X_W-1:0]     x, nxt_x;
  logic [Y_W-1:0]     y, nxt_y;
  logic [1:0]         mode_q, nxt_mode;
  logic [PIXEL_W-1:0] const_q, nxt_const;
  logic [PIXEL_W-1:0] nxt_fcnt;
  logic [PIXEL_W-1:0] pix;
  logic               accept;
  logic               frame_end;

  assign accept = strm.validout && strm.ready;

  // The registers always describe the beat on the bus, so everything here
  // computes the beat to present next; with no accept it equals the current
  // one, which keeps the outputs stable under stall.
  always_comb begin
    nxt_state = state;
    nxt_x     = x;
    nxt_y     = y;
    nxt_mode  = mode_q;
    nxt_const = const_q;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          nxt_state = ACTIVE;
          nxt_x     = '0;
          nxt_y     = '0;
          nxt_mode  = mode;
          nxt_const = const_val;
        end
      end
      ACTIVE: begin
        if (accept) begin
          nxt_x = x + 1'b1;
          if (x == X_ACT_LAST) nxt_state = HBLANK;
        end
      end
      HBLANK: begin
        if (accept) begin
          if (x == X_LAST) begin
            nxt_x = '0;
            if (y == Y_ACT_LAST) begin
              if (V_BLANK == 0) begin
                frame_end = 1'b1;
              end else begin
                nxt_y     = Y_VBL_1ST;
                nxt_state = VBLANK;
              end
            end else begin
              nxt_y     = y + 1'b1;
              nxt_state = ACTIVE;
            end
          end else begin
            nxt_x = x + 1'b1;
          end
        end
      end
      VBLANK: begin
        if (accept) begin
          if (x == X_LAST) begin
            nxt_x = '0;
            if (y == Y_LAST) frame_end = 1'b1;
            else             nxt_y = y + 1'b1;
          end else begin
            nxt_x = x + 1'b1;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
    // Frame boundary is the only place enable and the pattern inputs matter.
    if (frame_end) begin
      nxt_y = '0;
      if (enable) begin
        nxt_state = ACTIVE;
        nxt_mode  = mode;
        nxt_const = const_val;
      end else begin
        nxt_state = IDLE;
      end
    end
  end

`ifdef FRAME_STREAM_SCROLL_EN
  logic [PIXEL_W-1:0] frame_cnt;
  assign nxt_fcnt = frame_end ? frame_cnt + 1'b1 : frame_cnt;
`else
  assign nxt_fcnt = '0;
`endif

  frame_pattern_gen #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_pattern (
    .mode      (nxt_mode),
    .x         (nxt_x),
    .y         (nxt_y),
    .const_val (nxt_const),
    .frame_cnt (nxt_fcnt),
    .p         (pix)
  );

  // State, counters and the registered beat outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      x                 <= '0;
      y                 <= '0;
      mode_q            <= MODE_HRAMP;
      const_q           <= '0;
      strm.dout         <= '0;
      strm.blanking_out <= 1'b0;
      strm.validout     <= 1'b0;
      strm.sof          <= 1'b0;
`ifdef FRAME_STREAM_SCROLL_EN
      frame_cnt         <= '0;
`endif
    end else begin
      state             <= nxt_state;
      x                 <= nxt_x;
      y                 <= nxt_y;
      mode_q            <= nxt_mode;
      const_q           <= nxt_const;
      strm.dout         <= (nxt_state == ACTIVE) ? pix : '0;
      strm.blanking_out <= (nxt_state == HBLANK) || (nxt_state == VBLANK);
      strm.validout     <= (nxt_state != IDLE);
      strm.sof          <= (nxt_state == ACTIVE) && (nxt_x == '0) && (nxt_y == '0);
`ifdef FRAME_STREAM_SCROLL_EN
      frame_cnt         <= nxt_fcnt;
`endif
    end
  end

endmodule

// File: tb/tb_frame_stream_source.sv
// Self-checking bench for frame_stream_source. Two instances: a small 4x3
// raster (2 blank beats, 1 blank line) and a 16x16 raster for the checker.
// Expected beats come from a raster model that walks every (x, y) of a frame.
module tb_frame_stream_source;

`ifdef FRAME_STREAM_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       en_a = 1'b0;
  logic       en_b = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] cv = 8'd0;

  int checks = 0;
  int failures = 0;
  int stall_err = 0;
  int last_cycles = 0;

  // Beat packed as {sof, blanking_out, dout}.
  logic [9:0] exp_q[$];
  logic [9:0] cap_q[$];

  frame_stream_source_if ifa ();
  frame_stream_source_if ifb ();

  frame_stream_source #(
    .H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(3), .V_BLANK(1)
  ) dut_a (
    .clock(clock), .reset(reset), .enable(en_a), .mode(mode),
    .const_val(cv), .strm(ifa)
  );

  frame_stream_source #(
    .H_ACTIVE(16), .H_BLANK(2), .V_ACTIVE(16), .V_BLANK(1)
  ) dut_b (
    .clock(clock), .reset(reset), .enable(en_b), .mode(mode),
    .const_val(cv), .strm(ifb)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] model_pix(int md, int x, int y, int c, int fc);
    int f;
    f = SCROLL ? fc : 0;
    case (md)
      0:       return 8'((x + f) % 256);
      1:       return 8'((y + f) % 256);
      2:       return ((((x / 8) + (y / 8) + f) % 2) == 1) ? 8'hFF : 8'h00;
      default: return 8'(c);
    endcase
  endfunction

  // Appends one whole frame, in raster order, to the expected queue.
  task automatic build_frame(input int md, input int c, input int fc,
                             input int ha, input int hb, input int va, input int vb);
    for (int y = 0; y < va + vb; y++) begin
      for (int x = 0; x < ha + hb; x++) begin
        logic       blank;
        logic [7:0] d;
        blank = (x >= ha) || (y >= va);
        d = blank ? 8'h00 : model_pix(md, x, y, c, fc);
        exp_q.push_back({(x == 0 && y == 0), blank, d});
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    en_a = 1'b0;
    en_b = 1'b0;
    ifa.ready = 1'b0;
    ifb.ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    cap_q.delete();
    stall_err = 0;
  endtask

  // Drives ready each negedge and records every beat that will be accepted
  // on the following rising edge; also notes beats that changed while stalled.
  task automatic capture(input bit use_b, input int nbeats, input bit rand_ready);
    int         got;
    logic       rdy, v, prev_stall;
    logic [9:0] beat, prev_beat;
    got = 0;
    last_cycles = 0;
    prev_stall = 1'b0;
    prev_beat = '0;
    while (got < nbeats && last_cycles < 5000) begin
      @(negedge clock);
      last_cycles++;
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      ifa.ready = rdy;
      ifb.ready = rdy;
      if (use_b) begin
        v = ifb.validout;
        beat = {ifb.sof, ifb.blanking_out, ifb.dout};
      end else begin
        v = ifa.validout;
        beat = {ifa.sof, ifa.blanking_out, ifa.dout};
      end
      if (prev_stall && (!v || beat !== prev_beat)) stall_err++;
      if (v && rdy) begin
        cap_q.push_back(beat);
        got++;
      end
      prev_stall = v && !rdy;
      prev_beat = beat;
    end
    if (got < nbeats) begin
      checks++;
      failures++;
      $display("[TB] FAIL capture_timeout beats=%0d required=%0d", got, nbeats);
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if ({ifa.validout, ifa.sof, ifa.blanking_out, ifa.dout} !== 11'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%h required=000",
               {ifa.validout, ifa.sof, ifa.blanking_out, ifa.dout});
    end
    checks++;
    if (ifb.validout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_valid_b got=%b required=0", ifb.validout);
    end
    @(negedge clock);
    reset = 1'b0;
    ifa.ready = 1'b1;
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (ifa.validout !== 1'b0) begin
        failures++;
        $display("[TB] FAIL idle_valid got=%b required=0", ifa.validout);
      end
    end
  endtask

  task automatic test_hramp();
    apply_reset();
    mode = 2'd0;
    en_a = 1'b1;
    build_frame(0, 0, 0, 4, 2, 3, 1);
    build_frame(0, 0, 1, 4, 2, 3, 1);
    capture(1'b0, 48, 1'b0);
    checks++;
    if (last_cycles !== 48) begin
      failures++;
      $display("[TB] FAIL hramp_latency cycles=%0d required=48", last_cycles);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [9:0] g;
      g = (i < cap_q.size()) ? cap_q[i] : 10'bx;
      checks++;
      if (g !== exp_q[i]) begin
        failures++;
        $display("[TB] FAIL hramp beat=%0d got=%h required=%h", i, g, exp_q[i]);
      end
    end
  endtask

  task automatic test_vramp();
    apply_reset();
    mode = 2'd1;
    en_a = 1'b1;
    build_frame(1, 0, 0, 4, 2, 3, 1);
    capture(1'b0, 24, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [9:0] g;
      g = (i < cap_q.size()) ? cap_q[i] : 10'bx;
      checks++;
      if (g !== exp_q[i]) begin
        failures++;
        $display("[TB] FAIL vramp beat=%0d got=%h required=%h", i, g, exp_q[i]);
      end
    end
  endtask

  task automatic test_checker();
    apply_reset();
    mode = 2'd2;
    en_b = 1'b1;
    build_frame(2, 0, 0, 16, 2, 16, 1);
    capture(1'b1, 306, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [9:0] g;
      g = (i < cap_q.size()) ? cap_q[i] : 10'bx;
      checks++;
      if (g !== exp_q[i]) begin
        failures++;
        $display("[TB] FAIL checker beat=%0d got=%h required=%h", i, g, exp_q[i]);
      end
    end
  endtask

  task automatic test_flat();
    logic [7:0] cv2;
    apply_reset();
    mode = 2'd3;
    cv = 8'h5A;
    en_a = 1'b1;
    cv2 = 8'($urandom_range(0, 255));
    if (cv2 == 8'h5A) cv2 = 8'hA5;
    build_frame(3, 8'h5A, 0, 4, 2, 3, 1);
    build_frame(3, cv2, 1, 4, 2, 3, 1);
    capture(1'b0, 10, 1'b0);
    cv = cv2;
    capture(1'b0, 38, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [9:0] g;
      g = (i < cap_q.size()) ? cap_q[i] : 10'bx;
      checks++;
      if (g !== exp_q[i]) begin
        failures++;
        $display("[TB] FAIL flat beat=%0d got=%h required=%h", i, g, exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int md;
    apply_reset();
    md = $urandom_range(0, 3);
    mode = 2'(md);
    cv = 8'($urandom_range(0, 255));
    en_a = 1'b1;
    build_frame(md, cv, 0, 4, 2, 3, 1);
    build_frame(md, cv, 1, 4, 2, 3, 1);
    capture(1'b0, 48, 1'b1);
    checks++;
    if (stall_err !== 0) begin
      failures++;
      $display("[TB] FAIL stall_stable changes=%0d required=0", stall_err);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [9:0] g;
      g = (i < cap_q.size()) ? cap_q[i] : 10'bx;
      checks++;
      if (g !== exp_q[i]) begin
        failures++;
        $display("[TB] FAIL backpressure beat=%0d got=%h required=%h", i, g, exp_q[i]);
      end
    end
  endtask

  task automatic test_enable_drop();
    apply_reset();
    mode = 2'd0;
    en_a = 1'b1;
    build_frame(0, 0, 0, 4, 2, 3, 1);
    capture(1'b0, 5, 1'b0);
    en_a = 1'b0;
    capture(1'b0, 19, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [9:0] g;
      g = (i < cap_q.size()) ? cap_q[i] : 10'bx;
      checks++;
      if (g !== exp_q[i]) begin
        failures++;
        $display("[TB] FAIL enable_drop beat=%0d got=%h required=%h", i, g, exp_q[i]);
      end
    end
    repeat (4) begin
      @(negedge clock);
      checks++;
      if (ifa.validout !== 1'b0) begin
        failures++;
        $display("[TB] FAIL after_frame_valid got=%b required=0", ifa.validout);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int md;
    apply_reset();
    md = $urandom_range(0, 3);
    mode = 2'(md);
    cv = 8'($urandom_range(0, 255));
    en_a = 1'b1;
    capture(1'b0, 10, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if ({ifa.validout, ifa.sof, ifa.blanking_out, ifa.dout} !== 11'd0) begin
      failures++;
      $display("[TB] FAIL midframe_reset got=%h required=000",
               {ifa.validout, ifa.sof, ifa.blanking_out, ifa.dout});
    end
    @(negedge clock);
    reset = 1'b0;
    cap_q.delete();
    build_frame(md, cv, 0, 4, 2, 3, 1);
    capture(1'b0, 24, 1'b0);
    checks++;
    if (last_cycles !== 24) begin
      failures++;
      $display("[TB] FAIL restart_latency cycles=%0d required=24", last_cycles);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [9:0] g;
      g = (i < cap_q.size()) ? cap_q[i] : 10'bx;
      checks++;
      if (g !== exp_q[i]) begin
        failures++;
        $display("[TB] FAIL restart beat=%0d got=%h required=%h", i, g, exp_q[i]);
      end
    end
  endtask

  initial begin
    ifa.ready = 1'b0;
    ifb.ready = 1'b0;
    test_reset();
    test_hramp();
    test_vramp();
    test_checker();
    test_flat();
    test_backpressure();
    test_enable_drop();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_stream_source.md
Name: frame_stream_source

Overview:
- Single-clock video stream transmitter. Emits a raster of 8-bit pixels with an explicit blanking flag and valid strobe: the same data/blanking/valid beat stream that the downsampler emits and the 5x5 window and upsampler consume.
- Drives pipeline stages on the bench and in bring-up builds with no camera attached.
- Generates a selectable test pattern.
- Honours downstream back-pressure through a ready input.

Parameters:
H_ACTIVE, 400, active pixels per line
H_BLANK, 40, blanking beats per line
V_ACTIVE, 300, active lines per frame
V_BLANK, 10, blanking lines per frame (each H_ACTIVE+H_BLANK beats)

Ports:
clock  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous, active-high; clears all state
enable  in  1  level; start/continue frames
mode  in  2  pattern select, sampled at frame start
const_val  in  8  pixel value for mode 3, sampled at frame start
ready  in  1  downstream can accept the current beat
dout  out  8  pixel data (0 during blanking beats)
blanking_out  out  1  current beat is a blanking beat
validout  out  1  a beat is presented
sof  out  1  current beat is pixel (0,0) of a frame

Behaviour:
- Transfer occurs on a rising edge with validout=1 and ready=1 ("accept").
- While validout=1 and ready=0, dout, blanking_out and sof hold stable.
- All outputs are registered.
- Reset values: dout=0, blanking_out=0, validout=0, sof=0, state=IDLE, x=0, y=0.
- Counters:
  - x: 0..H_TOTAL-1, where H_TOTAL=H_ACTIVE+H_BLANK.
  - y: 0..V_TOTAL-1, where V_TOTAL=V_ACTIVE+V_BLANK.
  - Width of each counter is $clog2 of its total.
  - Both advance only on accept.
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE:
  - validout=0.
  - When enable=1: latch mode/const_val, x=y=0, go to ACTIVE.
  - The first beat is presented on the next cycle with sof=1 and blanking_out=0, so latency from enable to first validout is 1 cycle.
- ACTIVE:
  - Presents pixel(x,y) with blanking_out=0.
  - On accept at x==H_ACTIVE-1, go to HBLANK.
- HBLANK:
  - Presents blanking beats.
  - On accept at x==H_TOTAL-1: x=0.
  - If y==V_ACTIVE-1: y=V_ACTIVE and go to VBLANK (skipped if V_BLANK==0).
  - Otherwise: y+1 and go to ACTIVE.
- VBLANK:
  - Presents blanking beats.
  - On accept at x==H_TOTAL-1 and y==V_TOTAL-1:
    - If enable=1: frame ends, x=y=0, re-sample mode/const_val, go to ACTIVE.
    - If enable=0: go to IDLE and drop validout the following cycle.
- enable is checked only at frame boundaries. Deassertion mid-frame completes the frame, including its blanking.
- Pixel function (p = pattern value before the optional feature):
  - mode 0 (h-ramp): p = x[7:0]
  - mode 1 (v-ramp): p = y[7:0]
  - mode 2 (checker): p = (x[3]^y[3]) ? 8'hFF : 8'h00
  - mode 3 (flat): p = latched const_val
- Ramps wrap modulo 256.
- sof is high only while pixel (0,0) is presented. It holds under stall.
- Asynchronous reset mid-frame: outputs drop immediately, and no partial frame resumes after release.

Optional Feature:
- Macro: FRAME_STREAM_SCROLL_EN.
- Defined:
  - An 8-bit frame counter increments on each frame end and wraps.
  - Modes 0/1 output (p + frame_cnt) mod 256, giving a scrolling ramp.
  - Mode 2 XORs the checker phase with frame_cnt[0].
  - Mode 3 is unaffected.
  - Reset clears the counter.
- Undefined: no counter exists and the pattern is static.

Decomposition:
- Shared package holds:
  - FSM state encoding (2-bit localparams IDLE/ACTIVE/HBLANK/VBLANK).
  - Pattern mode constants MODE_HRAMP/VRAMP/CHECK/FLAT.
  - The 8-bit pixel width constant shared with downsampler/upsampler/window.
- One sub-module: frame_pattern_gen, a purely combinational map of (mode, x, y, const_val, frame_cnt) to p.
- The top holds the FSM, counters, and output registers.

Test Plan (H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_BLANK=1, unless noted):
- reset, enable=1, mode=0, ready=1 -> 24 consecutive beats; line 0 dout=0,1,2,3 then 2 blanking beats (dout=0, blanking_out=1); sof only on beat 0; 6 VBLANK beats; frame repeats.
- mode=1 -> active beats of line y carry dout=y (0,1,2).
- mode=2 with H_ACTIVE=16, V_ACTIVE=16 -> dout=00 for x<8,y<8; FF for x>=8,y<8.
- mode=3, const_val=8'h5A, change const_val mid-frame -> 5A held until next frame start.
- ready toggled pseudo-randomly -> dout/blanking_out/sof stable during stalls; accepted beat sequence identical to ready=1 case.
- enable dropped at beat 5 -> frame completes all 24 beats, validout=0 after; reset asserted at beat 10 -> validout=0 immediately, restart emits sof on first beat; with FRAME_STREAM_SCROLL_EN, frame 2 mode 0 line 0 = 1,2,3,4.
